// File: rtl/cpu_dmem_responder.sv
// Data-side responder for the single-cycle CPU: 240-byte RAM plus an I/O page (keypad FIFO, LEDs, timer).
// Latency: DOUT is combinational from ADDR and current state; writes land on the MW rising edge.
// Backpressure: none; a keypad event arriving while the FIFO is full is dropped and flags overflow.
// Ports: CLK/RESET_L clock and async active-low reset; ADDR/WDATA/MW CPU data access, DOUT read data;
//        KEY_VALID/KEY_CODE keypad events in; LED register out; KEY_PENDING = keypad FIFO non-empty.
module cpu_dmem_responder #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] IO_BASE    = 8'hF0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        WDATA,
  input  logic              MW,
  output logic [7:0]        DOUT,
  input  logic              KEY_VALID,
  input  logic [3:0]        KEY_CODE,
  output logic [7:0]        LED,
  output logic              KEY_PENDING
);

  localparam int RAM_SIZE = int'(IO_BASE);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_KEY    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_LED    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_TIMER  = ADDR_W'(3);

  logic [7:0]        ram [RAM_SIZE];
  logic [3:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [7:0]        timer;

  logic              is_ram;
  logic [ADDR_W-1:0] io_off;
  logic              wr_ram;
  logic              wr_status;
  logic              wr_key;
  logic              wr_led;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign is_ram    = (ADDR < IO_BASE);
  assign io_off    = ADDR - IO_BASE;
  assign wr_ram    = MW && is_ram;
  assign wr_status = MW && !is_ram && (io_off == OFF_STATUS);
  assign wr_key    = MW && !is_ram && (io_off == OFF_KEY);
  assign wr_led    = MW && !is_ram && (io_off == OFF_LED);

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // A pop on an empty FIFO is ignored. A pop on a full FIFO frees the slot
  // the same-cycle push needs, so that push is accepted instead of dropped.
  assign pop  = wr_key && !empty;
  assign push = KEY_VALID && (!full || pop);
  assign drop = KEY_VALID && full && !pop;

  assign KEY_PENDING = !empty;

  // RAM and FIFO storage carry no reset; reads of the FIFO are masked when empty.
  always_ff @(posedge CLK) begin
    if (wr_ram) ram[ADDR] <= WDATA;
    if (push)   fifo_mem[wr_ptr] <= KEY_CODE;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      LED      <= 8'h00;
      timer    <= 8'h00;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      timer <= timer + 8'd1;
      if (wr_led) LED <= WDATA;
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // A drop in the same cycle as a W1C clear leaves overflow set.
      if (drop)
        overflow <= 1'b1;
      else if (wr_status && WDATA[1])
        overflow <= 1'b0;
    end
  end

  always_comb begin
    DOUT = 8'h00;
    if (is_ram) begin
      DOUT = ram[ADDR];
    end else begin
      case (io_off)
        OFF_STATUS: DOUT = {6'b0, overflow, !empty};
        OFF_KEY:    DOUT = empty ? 8'h00 : {4'b0, fifo_mem[rd_ptr]};
        OFF_LED:    DOUT = LED;
        OFF_TIMER:  DOUT = timer;
        default:    DOUT = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/cpu_dmem_responder.md
Name: cpu_dmem_responder

Overview:
- Data-side responder for the single-cycle CPU: answers its data-memory accesses (address, write data, MW) and returns read data on the CPU's Din input in the same cycle.
- Combines a 240-byte data RAM with a small memory-mapped I/O page for the minesweeper board.
- The I/O page holds a keypad event FIFO, an LED register and a free-running timer used as a random seed.
- Sits between the CPU top level and the board I/O.

Parameters:
- ADDR_W, 8, data address width; address space is 2^ADDR_W bytes.
- IO_BASE, 8'hF0, first I/O address; RAM occupies 0 .. IO_BASE-1.
- FIFO_DEPTH, 4, keypad FIFO entries; must be a power of two, at least 2.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_L  input  1  asynchronous active-low reset.
- ADDR  input  ADDR_W  CPU data address.
- WDATA  input  8  CPU store data.
- MW  input  1  CPU memory-write strobe; a write occurs at the rising edge where MW=1.
- DOUT  output  8  read data to CPU Din; combinational from ADDR and current state.
- KEY_VALID  input  1  one-cycle pulse marking a keypad event, already synchronised.
- KEY_CODE  input  4  keycode qualified by KEY_VALID.
- LED  output  8  board LED register.
- KEY_PENDING  output  1  FIFO non-empty; usable as an interrupt or debug flag.

Behaviour:
- Reset, asynchronous while RESET_L=0:
  - LED=0, timer=0, FIFO empty (read pointer, write pointer and count all 0), overflow=0, KEY_PENDING=0.
  - RAM contents are not reset and are undefined until written.
  - DOUT follows the read map below using these reset values.
- Address map, reads are combinational with zero latency:
  - below IO_BASE: RAM[ADDR].
  - IO_BASE+0 STATUS: {6'b0, overflow, nonempty}.
  - IO_BASE+1 KEY: {4'b0, head keycode} when non-empty; 8'h00 when empty.
  - IO_BASE+2 LED: current LED value.
  - IO_BASE+3 TIMER: current timer value.
  - IO_BASE+4 and above: 8'h00.
- Writes, taking effect on the rising edge with MW=1; the new value is visible on DOUT in the following cycle:
  - RAM region: RAM[ADDR] <= WDATA.
  - STATUS: if WDATA[1]=1, overflow is cleared (write-1-to-clear); all other bits are ignored.
  - KEY: pops the FIFO head; WDATA is ignored; a pop when empty has no effect.
  - LED: LED <= WDATA.
  - TIMER and unmapped addresses: write ignored.
- Timer: 8-bit, increments every cycle, wraps 8'hFF -> 8'h00.
- Keypad FIFO: circular buffer of 4-bit entries with log2(FIFO_DEPTH)-bit pointers that wrap naturally.
  - Push when KEY_VALID=1 and not full. A push when full drops the code, sets overflow, and leaves pointers unchanged.
  - Push and pop in the same cycle:
    - non-empty: both occur and count is unchanged;
    - empty: the push occurs and the pop is ignored, so count becomes 1;
    - full: the pop frees a slot, so the push is accepted, count is unchanged, and overflow is not set.
  - Overflow set and a W1C clear in the same cycle: set wins.
- KEY_PENDING = (count != 0), driven registered-state only.
- No read side effects. The CPU has no read strobe, so all state changes happen only through MW writes or KEY_VALID.

Test Plan:
- Reset:
  - Action: assert RESET_L=0 mid-run with FIFO holding 2 entries and LED=8'hA5, then release.
  - Expected: LED=0, STATUS reads 8'h00, KEY reads 8'h00, TIMER reads 0 and then 1 on the next cycle, KEY_PENDING=0.
- RAM:
  - Action: write 8'h3C to 8'h10 and 8'hC3 to 8'hEF, then read both.
  - Expected: DOUT=8'h3C and 8'hC3.
  - Action: write to 8'hF3.
  - Expected: TIMER keeps counting, unaffected.
- FIFO order:
  - Action: push codes 1, 2, 3.
  - Expected: STATUS=8'h01 and KEY=8'h01; after each pop write, KEY reads 8'h02, 8'h03, then 8'h00; STATUS=8'h00 and KEY_PENDING=0 at the end.
- Overflow:
  - Action: push 5 codes 1..5 with no pops.
  - Expected: STATUS=8'h03 and the fifth code is dropped; four pops return 1, 2, 3, 4.
  - Action: write STATUS with WDATA=8'h02.
  - Expected: STATUS reads 8'h00.
- Simultaneous push and pop:
  - Action: with FIFO full (codes 1..4), pop plus push code 9 in the same cycle.
  - Expected: overflow stays 0 and contents become 2, 3, 4, 9.
  - Action: with FIFO empty, pop plus push code 7 in the same cycle.
  - Expected: KEY=8'h07 and count is 1.
- Timer wrap and overflow priority:
  - Action: run 256 cycles after reset.
  - Expected: TIMER returns to 8'h00.
  - Action: with FIFO full, write STATUS=8'h02 in the same cycle as a dropped push.
  - Expected: overflow remains 1.
